// File: rtl/aes_round_sched_pkg.sv
// Shared types and round-count decode for the iterative AES round scheduler.
package aes_round_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        ROUND,
        OUT,
        DONE
    } aes_sched_state_t;

    typedef enum logic [1:0] {
        KEY_128  = 2'd0,
        KEY_192  = 2'd1,
        KEY_256  = 2'd2,
        KEY_RSVD = 2'd3
    } aes_key_len_t;

    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;

    // Reserved key length decodes to 0; the scheduler rejects it before use.
    function automatic logic [3:0] aes_nr(input aes_key_len_t key_len);
        case (key_len)
            KEY_128: aes_nr = 4'(AES_NR_128);
            KEY_192: aes_nr = 4'(AES_NR_192);
            KEY_256: aes_nr = 4'(AES_NR_256);
            default: aes_nr = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_sched.sv
// Block/round sequencer for the iterative AES datapath: accepts plaintext,
// steps Nr rounds with key expansion, and hands the ciphertext to the sink.
module aes_round_sched
    import aes_round_sched_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int RND_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable_i,
    input  logic             start_i,
    input  logic [1:0]       key_len_i,
    input  logic [CNT_W-1:0] num_blocks_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             load_o,
    output logic             key_restart_o,
    output logic             round_en_o,
    output logic             key_step_o,
    output logic [RND_W-1:0] round_idx_o,
    output logic             last_round_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] blocks_done_o
);

    aes_sched_state_t state;
    logic [RND_W-1:0] round_cnt;
    logic [RND_W-1:0] nr;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] blocks_done;
    logic             err_q;
    logic             in_round;

    // NOTE: every register here is written with <= so all updates in a cycle
    // see the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state       <= IDLE;
            round_cnt   <= '0;
            nr          <= '0;
            remaining   <= '0;
            blocks_done <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (aes_key_len_t'(key_len_i) == KEY_RSVD) begin
                            err_q <= 1'b1;
                        end else begin
                            nr          <= RND_W'(aes_nr(aes_key_len_t'(key_len_i)));
                            remaining   <= num_blocks_i;
                            blocks_done <= '0;
                            state       <= (num_blocks_i == '0) ? DONE : WAIT_IN;
                        end
                    end
                end
                WAIT_IN: begin
                    if (in_valid_i) begin
                        round_cnt <= RND_W'(1);
                        state     <= ROUND;
                    end
                end
                ROUND: begin
                    // A deasserted enable freezes the round counter and state.
                    if (enable_i) begin
                        if (round_cnt == nr) begin
                            round_cnt <= '0;
                            state     <= OUT;
                        end else begin
                            round_cnt <= round_cnt + RND_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        blocks_done <= blocks_done + CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                        end else begin
                            remaining <= remaining - CNT_W'(1);
                            state     <= WAIT_IN;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode the state register only, so neither ready nor
    // valid depends combinationally on the partner's signal.
    assign in_round      = (state == ROUND);
    assign in_ready_o    = (state == WAIT_IN);
    assign load_o        = in_ready_o && in_valid_i;
    assign key_restart_o = load_o;
    assign round_en_o    = in_round && enable_i;
    assign key_step_o    = round_en_o;
    assign round_idx_o   = in_round ? round_cnt : '0;
    assign last_round_o  = in_round && (round_cnt == nr);
    assign out_valid_o   = (state == OUT);
    assign busy_o        = (state != IDLE);
    assign done_o        = (state == DONE);
    assign err_o         = err_q;
    assign blocks_done_o = blocks_done;

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: table of whole-job vectors plus
// hand-written sequences for zero-block, reserved key, and mid-job clear.
module tb_aes_round_sched;

    localparam int CNT_W = 16;
    localparam int RND_W = 4;

    logic             clk;
    logic             reset;
    logic             clear;
    logic             enable_i;
    logic             start_i;
    logic [1:0]       key_len_i;
    logic [CNT_W-1:0] num_blocks_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             load_o;
    logic             key_restart_o;
    logic             round_en_o;
    logic             key_step_o;
    logic [RND_W-1:0] round_idx_o;
    logic             last_round_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] blocks_done_o;

    aes_round_sched #(.CNT_W(CNT_W), .RND_W(RND_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .enable_i     (enable_i),
        .start_i      (start_i),
        .key_len_i    (key_len_i),
        .num_blocks_i (num_blocks_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .load_o       (load_o),
        .key_restart_o(key_restart_o),
        .round_en_o   (round_en_o),
        .key_step_o   (key_step_o),
        .round_idx_o  (round_idx_o),
        .last_round_o (last_round_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .blocks_done_o(blocks_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int load_cnt = 0;
    int done_cnt = 0;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (load_o) load_cnt <= load_cnt + 1;
        if (done_o) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        int kl;
        int nblk;
        int nr;
        int stall_round;
        int stall_len;
        int hold_blk;
        int hold_len;
        int lat;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic start_job(input int kl, input int n);
        start_i      = 1'b1;
        key_len_i    = 2'(kl);
        num_blocks_i = CNT_W'(n);
        settle();
        check("idle_busy", 32'(busy_o), 0);
        tick();
        start_i = 1'b0;
        // Scramble job inputs; the latched copies must be used.
        key_len_i    = 2'd3;
        num_blocks_i = '0;
        settle();
        check("busy_after_start", 32'(busy_o), 1);
    endtask

    task automatic feed_block(input int b, input int nr, input int lat,
                              input int stall_round, input int stall_len);
        int t0;
        int r;
        int stalled;
        in_valid_i = 1'b1;
        settle();
        for (int k = 0; k < 20 && !in_ready_o; k++) begin
            tick();
            settle();
        end
        check("in_ready", 32'(in_ready_o), 1);
        check("load_on_accept", 32'(load_o), 1);
        check("key_restart_on_accept", 32'(key_restart_o), 1);
        t0 = cyc;
        tick();
        in_valid_i = 1'b0;
        r       = 1;
        stalled = 0;
        while (!out_valid_o && (cyc - t0) < 60) begin
            if (r == stall_round && stalled < stall_len) begin
                enable_i = 1'b0;
                settle();
                check("stall_round_idx", 32'(round_idx_o), 32'(r));
                check("stall_round_en", 32'(round_en_o), 0);
                check("stall_key_step", 32'(key_step_o), 0);
                stalled++;
            end else begin
                enable_i = 1'b1;
                settle();
                check("round_idx", 32'(round_idx_o), 32'(r));
                check("round_en", 32'(round_en_o), 1);
                check("key_step", 32'(key_step_o), 1);
                check("last_round", 32'(last_round_o), 32'(r == nr));
                r++;
            end
            tick();
        end
        enable_i = 1'b1;
        check("out_valid_seen", 32'(out_valid_o), 1);
        check("out_latency", 32'(cyc - t0), 32'(lat));
        check("rounds_per_block", 32'(r - 1), 32'(nr));
        check("round_idx_in_out", 32'(round_idx_o), 0);
        if (b < 0) $display("unexpected block index %0d", b);
    endtask

    task automatic drain_block(input int b, input int hold);
        for (int i = 0; i < hold; i++) begin
            out_ready_i  = 1'b0;
            start_i      = (i == 2);
            key_len_i    = 2'd0;
            num_blocks_i = CNT_W'(1);
            settle();
            check("out_valid_hold", 32'(out_valid_o), 1);
            check("blocks_done_hold", 32'(blocks_done_o), 32'(b));
            tick();
            start_i = 1'b0;
        end
        out_ready_i = 1'b1;
        settle();
        check("out_valid_handshake", 32'(out_valid_o), 1);
        tick();
        out_ready_i = 1'b0;
        settle();
        check("blocks_done_inc", 32'(blocks_done_o), 32'(b + 1));
    endtask

    task automatic finish_job(input int n);
        check("done_pulse", 32'(done_o), 1);
        check("busy_in_done", 32'(busy_o), 1);
        tick();
        settle();
        check("done_clears", 32'(done_o), 0);
        check("busy_clears", 32'(busy_o), 0);
        check("blocks_done_final", 32'(blocks_done_o), 32'(n));
    endtask

    task automatic run_vec(input vec_t v);
        int ld0;
        int dn0;
        ld0 = load_cnt;
        dn0 = done_cnt;
        start_job(v.kl, v.nblk);
        for (int b = 0; b < v.nblk; b++) begin
            if (b == 0)
                feed_block(b, v.nr, v.lat, v.stall_round, v.stall_len);
            else
                feed_block(b, v.nr, v.nr + 1, 0, 0);
            drain_block(b, (b == v.hold_blk) ? v.hold_len : 0);
        end
        finish_job(v.nblk);
        tick();
        check("load_pulses", 32'(load_cnt - ld0), 32'(v.nblk));
        check("single_done", 32'(done_cnt - dn0), 1);
    endtask

    initial begin
        int d0;
        //           kl nblk nr stall_rnd stall_len hold_blk hold_len lat
        vecs[0] = '{0, 1, 10, 0, 0, -1, 0, 11};
        vecs[1] = '{2, 3, 14, 0, 0,  1, 5, 15};
        vecs[2] = '{1, 1, 12, 6, 4, -1, 0, 17};
        vecs[3] = '{1, 2, 12, 0, 0, -1, 0, 13};

        reset        = 1'b1;
        clear        = 1'b0;
        enable_i     = 1'b1;
        start_i      = 1'b0;
        key_len_i    = 2'd0;
        num_blocks_i = '0;
        in_valid_i   = 1'b0;
        out_ready_i  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        settle();
        check("rst_busy", 32'(busy_o), 0);
        check("rst_in_ready", 32'(in_ready_o), 0);
        check("rst_out_valid", 32'(out_valid_o), 0);
        check("rst_round_idx", 32'(round_idx_o), 0);
        check("rst_blocks_done", 32'(blocks_done_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        tick();

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Zero-block job: straight to DONE, no load.
        d0 = load_cnt;
        start_i      = 1'b1;
        key_len_i    = 2'd0;
        num_blocks_i = '0;
        tick();
        start_i = 1'b0;
        settle();
        check("zero_done", 32'(done_o), 1);
        check("zero_in_ready", 32'(in_ready_o), 0);
        tick();
        settle();
        check("zero_done_clears", 32'(done_o), 0);
        check("zero_busy_clears", 32'(busy_o), 0);
        check("zero_no_load", 32'(load_cnt - d0), 0);

        // Reserved key length: err pulse, stays idle.
        start_i      = 1'b1;
        key_len_i    = 2'd3;
        num_blocks_i = CNT_W'(5);
        tick();
        start_i = 1'b0;
        settle();
        check("err_pulse", 32'(err_o), 1);
        check("err_busy", 32'(busy_o), 0);
        tick();
        settle();
        check("err_clears", 32'(err_o), 0);
        check("err_still_idle", 32'(busy_o), 0);

        // Clear during ROUND of block 2 of 4.
        start_job(0, 4);
        feed_block(0, 10, 11, 0, 0);
        drain_block(0, 0);
        in_valid_i = 1'b1;
        settle();
        check("clr_accept_load", 32'(load_o), 1);
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        settle();
        check("clr_pre_round_idx", 32'(round_idx_o), 3);
        d0    = done_cnt;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        settle();
        check("clr_busy", 32'(busy_o), 0);
        check("clr_round_idx", 32'(round_idx_o), 0);
        check("clr_round_en", 32'(round_en_o), 0);
        check("clr_key_step", 32'(key_step_o), 0);
        check("clr_last_round", 32'(last_round_o), 0);
        check("clr_out_valid", 32'(out_valid_o), 0);
        check("clr_in_ready", 32'(in_ready_o), 0);
        check("clr_blocks_done", 32'(blocks_done_o), 0);
        check("clr_done", 32'(done_o), 0);
        check("clr_err", 32'(err_o), 0);
        repeat (3) tick();
        check("clr_no_done", 32'(done_cnt - d0), 0);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
